// File: rtl/i2s_transmitter.sv
// I2S transmitter: serializes stereo sample pairs onto DAC pins from one free-running frame counter.
// Optional underrun counter output enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_transmitter #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int BCLK_HALF    = 16,
    parameter int MCLK_HALF    = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic signed [SAMPLE_WIDTH-1:0] in_left,
    input  logic signed [SAMPLE_WIDTH-1:0] in_right,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           underrun,
    output logic                           dac_sys_clk,
    output logic                           dac_bit_clk,
    output logic                           dac_lr_clk,
    output logic                           dac_data
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                    underrun_count
`endif
);

    localparam int BCLK_LOG = $clog2(BCLK_HALF);
    localparam int MCLK_LOG = $clog2(MCLK_HALF);
    localparam int CNT_W    = 6 + BCLK_LOG + 1;

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [5:0]                    k_d;
    logic                          load;
    logic [63:0]                   frame_q, frame_d;
    logic signed [SAMPLE_WIDTH-1:0] hold_left_q, hold_right_q;
    logic signed [31:0]            left_ext, right_ext;
    logic                          ready_q, ready_d;
    logic                          accept;
    logic                          underrun_q, underrun_d;
    logic                          sys_q, bit_q, lr_q, data_q;
    logic                          data_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        k_d        = cnt_d[CNT_W-1 -: 6];
        load       = (cnt_d == '0);
        accept     = in_valid & ready_q;
        left_ext   = 32'(hold_left_q);
        right_ext  = 32'(hold_right_q);
        frame_d    = frame_q;
        ready_d    = ready_q;
        underrun_d = 1'b0;

        // The load sees the holding register as it was before this edge's capture.
        if (load) begin
            if (!ready_q) begin
                frame_d = {left_ext, right_ext};
                ready_d = 1'b1;
            end else begin
                frame_d    = '0;
                underrun_d = 1'b1;
            end
        end
        if (accept) begin
            ready_d = 1'b0;
        end

        // frame[63-k] == frame[~k] for a 6-bit k.
        data_d = frame_d[~k_d];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '1;
            frame_q    <= '0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
            sys_q      <= 1'b0;
            bit_q      <= 1'b0;
            lr_q       <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            sys_q      <= cnt_d[MCLK_LOG];
            bit_q      <= cnt_d[BCLK_LOG];
            lr_q       <= ~k_d[5];
            data_q     <= data_d;
        end
    end

    // NOTE: the holding data needs no reset; it is only ever read when ready_q says it is full.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_left_q  <= in_left;
            hold_right_q <= in_right;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ucnt_q <= '0;
        end else if (underrun_d && ucnt_q != 16'hFFFF) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count = ucnt_q;
`endif

    assign in_ready    = ready_q;
    assign underrun    = underrun_q;
    assign dac_sys_clk = sys_q;
    assign dac_bit_clk = bit_q;
    assign dac_lr_clk  = lr_q;
    assign dac_data    = data_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: queue-based frame model, per-cycle pin check, I2S receiver decode.
module tb_i2s_transmitter;

    localparam int SW    = 24;
    localparam int FRAME = 2048;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic signed [SW-1:0] in_left = '0;
    logic signed [SW-1:0] in_right = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready, underrun;
    logic                 dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]          underrun_count;
`endif

    i2s_transmitter #(.SAMPLE_WIDTH(SW), .BCLK_HALF(16), .MCLK_HALF(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .underrun    (underrun),
        .dac_sys_clk (dac_sys_clk),
        .dac_bit_clk (dac_bit_clk),
        .dac_lr_clk  (dac_lr_clk),
        .dac_data    (dac_data)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: time position in the frame, a 1-entry pending queue, the frame on the wire.
    int          t_cnt = FRAME - 1;
    logic [63:0] hold_q[$];
    logic [63:0] exp_frames[$];
    logic [63:0] m_frame = '0;
    logic        m_ready = 1'b1;
    logic        m_underrun = 1'b0;
    logic [15:0] m_ucount = '0;
    logic        acc = 1'b0;

    function automatic logic [31:0] sext32(input logic [SW-1:0] v);
        logic [31:0] x;
        x = {8'b0, v};
        if (v[SW-1]) x = x - 32'h0100_0000;
        return x;
    endfunction

    task automatic model_reset();
        t_cnt      = FRAME - 1;
        hold_q.delete();
        exp_frames.delete();
        m_frame    = '0;
        m_ready    = 1'b1;
        m_underrun = 1'b0;
        m_ucount   = '0;
    endtask

    task automatic step();
        logic       take;
        logic [5:0] exp_pins;
        @(posedge clk);
        take  = in_valid && m_ready;
        acc   = take;
        t_cnt = (t_cnt + 1) % FRAME;
        m_underrun = 1'b0;
        if (t_cnt == 0) begin
            if (hold_q.size() > 0) begin
                m_frame = hold_q.pop_front();
            end else begin
                m_frame    = '0;
                m_underrun = 1'b1;
            end
            exp_frames.push_back(m_frame);
        end
        if (take) hold_q.push_back({sext32(in_left), sext32(in_right)});
        m_ready = (hold_q.size() == 0);
        if (m_underrun && m_ucount != 16'hFFFF) m_ucount++;
        #1;
        exp_pins = {m_ready, m_underrun, 1'((t_cnt / 4) % 2), 1'((t_cnt / 16) % 2),
                    (t_cnt < FRAME / 2), m_frame[63 - t_cnt / 32]};
        check("pins", {58'b0, in_ready, underrun, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data},
              {58'b0, exp_pins});
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_count", {48'b0, underrun_count}, {48'b0, m_ucount});
`endif
    endtask

    task automatic run_to(input int c);
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (t_cnt == c) break;
        end
    endtask

    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (acc) break;
        end
        in_valid = 1'b0;
        check("send_accepted", {63'b0, acc}, 64'd1);
    endtask

    // Receiver: samples on bit-clock rise, frame boundary at word-select 0->1.
    logic [63:0] rx_sr;
    int          rx_cnt;
    logic        rx_prev_lr;
    logic [63:0] dec_last = '0;
    int          n_dec = 0;

    always @(posedge dac_bit_clk or negedge rstn) begin
        if (!rstn) begin
            rx_sr      = '0;
            rx_cnt     = 0;
            rx_prev_lr = 1'b0;
        end else begin
            if (dac_lr_clk && !rx_prev_lr) begin
                if (rx_cnt == 64) begin
                    logic [63:0] exp;
                    exp = (exp_frames.size() > 0) ? exp_frames.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                    check("rx_frame", rx_sr, exp);
                    dec_last = rx_sr;
                    n_dec++;
                end
                rx_cnt = 0;
            end
            rx_sr      = {rx_sr[62:0], dac_data};
            rx_cnt     = rx_cnt + 1;
            rx_prev_lr = dac_lr_clk;
        end
    end

    initial begin
        int n;
        #23;
        check("reset_pins", {58'b0, in_ready, underrun, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data},
              64'b100000);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Three idle frames: underrun at every frame start, silence on the wire.
        step();
        run_to(0);
        run_to(0);

        // Known pairs, then decoded and checked through the receiver.
        send(24'h123456, 24'hFEDCBA);
        run_to(0);
        send(24'h800001, 24'($urandom));
        run_to(0);
        run_to(20);
        check("dec_left_half", {32'b0, dec_last[63:32]}, 64'h0000_0000_0012_3456);
        check("dec_right24", {40'b0, dec_last[23:0]}, 64'h0000_0000_00FE_DCBA);
        run_to(0);
        run_to(20);
        check("dec_neg_half", {32'b0, dec_last[63:32]}, 64'h0000_0000_FF80_0001);
        check("dec_neg_value", 64'(signed'(dec_last[55:32])), 64'(-64'sd8388607));

        // Continuous producer with incrementing values.
        n = 0;
        in_valid = 1'b1;
        in_left  = 24'(n);
        in_right = 24'(n);
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            if (acc) begin
                n++;
                in_left  = 24'(n);
                in_right = 24'(n);
            end
        end
        in_valid = 1'b0;
        run_to(0);
        run_to(0);

        // Valid only in the load cycle with holding empty: underrun, pair carried to next frame.
        run_to(FRAME - 1);
        in_valid = 1'b1;
        in_left  = 24'h0A0B0C;
        in_right = 24'hF0F0F0;
        step();
        in_valid = 1'b0;
        check("loadcyc_underrun", {63'b0, underrun}, 64'd1);
        check("loadcyc_ready", {63'b0, in_ready}, 64'd0);
        run_to(0);
        run_to(20);
        run_to(0);
        run_to(20);
        check("loadcyc_dec", dec_last, {sext32(24'h0A0B0C), sext32(24'hF0F0F0)});

        // Random producer.
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (!in_valid && $urandom_range(0, 499) == 0) begin
                in_valid = 1'b1;
                in_left  = 24'($urandom);
                in_right = 24'($urandom);
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;

        // Mid-frame reset with a pair held: frame aborted, pair dropped.
        run_to(5);
        send(24'h7FFFFF, 24'h000001);
        run_to(40 * 32 + 3);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_pins", {58'b0, in_ready, underrun, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data},
              64'b100000);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("held_reset_pins", {58'b0, in_ready, underrun, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data},
              64'b100000);
        rstn = 1'b1;
        step();
        check("restart_lr", {63'b0, dac_lr_clk}, 64'd1);
        check("restart_underrun", {63'b0, underrun}, 64'd1);
        run_to(0);
        run_to(20);
        check("restart_silence", dec_last, 64'd0);
        check("rx_decoded_many", {63'b0, (n_dec > 10)}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
